mem_stage: RTL

- Memory-access stage of the 5-stage MIPS pipeline, between EX and WB.
- Takes the EX result and load/store control, and performs one word or byte access on a single-outstanding-request data-memory port.
- Registers the results into the WB-facing outputs: ALU result, 4-byte read lanes, byte offset, rd number, register source, halt.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline. It issues one word or byte
// access on a single-outstanding-request port and registers the results for WB.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             is_word,
    input  logic [31:0]      ALU_result,
    input  logic [31:0]      store_data,
    input  logic [1:0]       register_src_in,
    input  logic [4:0]       rd_num_in,
    input  logic [31:0]      inst_addr_in,
    input  logic             halted_in,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_en,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             wb_valid,
    output logic [31:0]      ALU_result_out,
    output logic [3:0][7:0]  cache_data_out,
    output logic [1:0]       byte_number,
    output logic             is_word_out,
    output logic [1:0]       register_src,
    output logic [4:0]       rd_num_out,
    output logic [31:0]      inst_addr,
    output logic             halted_out,
    output logic             mem_error
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Copy of the accepted instruction, so completion does not rely on EX holding it.
    logic [31:0] p_alu, p_iaddr;
    logic        p_word, p_read;
    logic [1:0]  p_src;
    logic [4:0]  p_rd;

    logic        in_wait, is_mem, bad_op, idle_acc, start, done, tmo, retire, abort;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] sel_alu, sel_iaddr;
    logic        sel_word;
    logic [1:0]  sel_src;
    logic [4:0]  sel_rd;

    assign in_wait  = (state == S_WAIT);
    assign is_mem   = mem_read | mem_write;
    assign bad_op   = (mem_read & mem_write) | (is_mem & is_word & (ALU_result[1:0] != 2'b00));
    assign idle_acc = ~in_wait & in_valid;
    assign start    = idle_acc & ~halted_in & is_mem & ~bad_op;
    assign done     = in_wait & mem_ready;
    assign tmo      = in_wait & ~mem_ready & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign retire   = (idle_acc & ~start) | done | tmo;
    assign abort    = (idle_acc & ~halted_in & bad_op) | tmo;
    assign stall    = start | (in_wait & ~mem_ready & ~tmo);

    assign sel_alu   = in_wait ? p_alu   : ALU_result;
    assign sel_iaddr = in_wait ? p_iaddr : inst_addr_in;
    assign sel_word  = in_wait ? p_word  : is_word;
    assign sel_src   = in_wait ? p_src   : register_src_in;
    assign sel_rd    = in_wait ? p_rd    : rd_num_in;

    // Big-endian lanes: byte offset k lives in lane 3-k.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign req_be[l]            = is_word | (ALU_result[1:0] == 2'(3 - l));
        assign req_wdata[8*l +: 8]  = is_word ? store_data[8*l +: 8] : store_data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_byte_en    <= '0;
            wb_valid       <= 1'b0;
            ALU_result_out <= '0;
            cache_data_out <= '0;
            byte_number    <= '0;
            is_word_out    <= 1'b0;
            register_src   <= '0;
            rd_num_out     <= '0;
            inst_addr      <= '0;
            halted_out     <= 1'b0;
            mem_error      <= 1'b0;
            p_alu          <= '0;
            p_iaddr        <= '0;
            p_word         <= 1'b0;
            p_read         <= 1'b0;
            p_src          <= '0;
            p_rd           <= '0;
        end else begin
            wb_valid <= retire;
            if (retire) begin
                ALU_result_out <= sel_alu;
                byte_number    <= sel_alu[1:0];
                is_word_out    <= sel_word;
                register_src   <= sel_src;
                inst_addr      <= sel_iaddr;
                rd_num_out     <= abort ? 5'd0 : sel_rd;
                halted_out     <= abort | (~in_wait & halted_in);
                cache_data_out <= (done & p_read) ? mem_rdata : 32'd0;
            end else begin
                rd_num_out <= '0;
            end
            if (abort) mem_error <= 1'b1;

            if (!in_wait) begin
                if (start) begin
                    state       <= S_WAIT;
                    cnt         <= '0;
                    mem_req     <= 1'b1;
                    mem_we      <= mem_write;
                    mem_addr    <= {ALU_result[31:2], 2'b00};
                    mem_wdata   <= req_wdata;
                    mem_byte_en <= req_be;
                    p_alu       <= ALU_result;
                    p_iaddr     <= inst_addr_in;
                    p_word      <= is_word;
                    p_read      <= mem_read;
                    p_src       <= register_src_in;
                    p_rd        <= rd_num_in;
                end
            end else if (done || tmo) begin
                state   <= S_IDLE;
                mem_req <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
